// File: rtl/rom_port_arbiter.sv
// Two-requester, round-robin arbiter in front of a single ROM read port.
// One transaction in flight at a time; every output comes straight from a flop.

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module rom_port_arbiter #(
  parameter int ADDR_WIDTH     = `RISCV_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `RISCV_WORD_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_ready_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_valid_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_ready_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,
  output logic                  rom_valid_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic                  rom_ready_i,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  rom_valid_q, rom_valid_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]            ready_q, ready_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  busy_q, busy_d;

  logic                  grant_sel;
  logic                  resp_fire;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  // last_gnt doubles as the index of the requester currently being served.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    rom_valid_d = 1'b0;
    rom_addr_d  = rom_addr_q;
    ready_d     = 2'b00;
    err_d       = 2'b00;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    grant_sel   = ~last_gnt_q;
    resp_fire   = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    case (state_q)
      IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          if (!(m0_valid_i && m1_valid_i)) begin
            grant_sel = m1_valid_i;
          end
          last_gnt_d  = grant_sel;
          rom_valid_d = 1'b1;
          rom_addr_d  = grant_sel ? m1_addr_i : m0_addr_i;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A ROM strobe on the timeout edge still delivers real data.
        if (rom_ready_i) begin
          resp_fire = 1'b1;
          resp_data = rom_rdata_i;
        end else if (cnt_d == TIMEOUT_LIMIT) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
        if (resp_fire) begin
          state_d             = RESP;
          ready_d[last_gnt_q] = 1'b1;
          err_d[last_gnt_q]   = resp_err;
          if (last_gnt_q) begin
            m1_rdata_d = resp_data;
          end else begin
            m0_rdata_d = resp_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= 1'b1;
      rom_valid_q <= 1'b0;
      rom_addr_q  <= '0;
      ready_q     <= 2'b00;
      err_q       <= 2'b00;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      rom_valid_q <= rom_valid_d;
      rom_addr_q  <= rom_addr_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign rom_valid_o = rom_valid_q;
  assign rom_addr_o  = rom_addr_q;
  assign m0_ready_o  = ready_q[0];
  assign m0_err_o    = err_q[0];
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_ready_o  = ready_q[1];
  assign m1_err_o    = err_q[1];
  assign m1_rdata_o  = m1_rdata_q;
  assign busy_o      = busy_q;

endmodule
